// File: rtl/randomnum_pkg.sv
// Shared definitions for the random-number requester: value range and FSM states.
package randomnum_pkg;

    localparam int          VAL_W   = 4;
    localparam logic [3:0]  VAL_MIN = 4'd1;
    localparam logic [3:0]  VAL_MAX = 4'd11;

    // state  | meaning
    // IDLE   | waiting for start
    // ISSUE  | request pulse when the output FIFO can take the coming draw
    // WAIT   | waiting for ready from the responder, timer running
    // DONE   | all draws captured, done pulse
    // ERR    | timeout or out-of-range value, error pulse
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        ERR
    } req_state_t;

    // True when a returned value lies in the legal draw range.
    function automatic logic val_in_range(input logic [VAL_W-1:0] v);
        return (v >= VAL_MIN) && (v <= VAL_MAX);
    endfunction

endpackage

// File: rtl/randomnum_fifo.sv
// Small synchronous FIFO; pointers carry one extra MSB so full and empty are distinct.
module randomnum_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] data_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next pointer values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/randomnum_requester.sv
// Requester side of the random-number link: issues request pulses, captures and
// range-checks returned values, accumulates their sum and buffers them for a consumer.
module randomnum_requester
    import randomnum_pkg::*;
#(
    parameter  int NUM_DRAWS  = 8,
    parameter  int FIFO_DEPTH = 4,
    parameter  int TIMEOUT    = 15,
    localparam int SUM_W      = $clog2(11*NUM_DRAWS+1)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             req_o,
    input  logic [VAL_W-1:0] value_i,
    input  logic             ready_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [SUM_W-1:0] sum_o,
    output logic             out_valid_o,
    output logic [VAL_W-1:0] out_data_o,
    input  logic             out_ready_i
);

    localparam int                CNT_W     = $clog2(NUM_DRAWS+1);
    localparam int                TMR_W     = $clog2(TIMEOUT+1);
    localparam logic [CNT_W-1:0]  LAST_DRAW = CNT_W'(NUM_DRAWS-1);
    localparam logic [TMR_W-1:0]  LAST_TICK = TMR_W'(TIMEOUT-1);

    req_state_t       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             push;
    logic             fifo_full;
    logic             fifo_empty;

    randomnum_fifo #(
        .WIDTH (VAL_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (out_ready_i),
        .data_i  (value_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_o  (out_data_o)
    );

    assign out_valid_o = !fifo_empty;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign error_o     = (state_q == ERR);
    assign sum_o       = sum_q;

    // Next-state, request and capture decisions.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        timer_d = timer_q;
        sum_d   = sum_q;
        req_o   = 1'b0;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = ISSUE;
                    count_d = '0;
                    sum_d   = '0;
                end
            end
            ISSUE: begin
                // Only WAIT pushes, so a free slot now is still free when the value returns.
                if (!fifo_full) begin
                    req_o   = 1'b1;
                    timer_d = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (ready_i) begin
                    if (val_in_range(value_i)) begin
                        push    = 1'b1;
                        sum_d   = sum_q + SUM_W'(value_i);
                        count_d = count_q + CNT_W'(1);
                        state_d = (count_q == LAST_DRAW) ? DONE : ISSUE;
                    end else begin
                        state_d = ERR;
                    end
                end else if (timer_q == LAST_TICK) begin
                    state_d = ERR;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, draw counter, timer and sum registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            timer_q <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            timer_q <= timer_d;
            sum_q   <= sum_d;
        end
    end

endmodule

// File: tb/tb_randomnum_requester.sv
// Self-checking bench: behavioural responder and consumer with a value scoreboard.
module tb_randomnum_requester;

    localparam int ND = 8;
    localparam int FD = 4;
    localparam int TO = 15;
    localparam int SW = $clog2(11*ND+1);

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [3:0]    value;
    logic          ready;
    logic          start;
    logic          busy;
    logic          done;
    logic          error;
    logic [SW-1:0] sum;
    logic          out_valid;
    logic [3:0]    out_data;
    logic          out_ready;

    always #5 clk = ~clk;

    randomnum_requester #(
        .NUM_DRAWS  (ND),
        .FIFO_DEPTH (FD),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_o       (req),
        .value_i     (value),
        .ready_i     (ready),
        .start_i     (start),
        .busy_o      (busy),
        .done_o      (done),
        .error_o     (error),
        .sum_o       (sum),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready)
    );

    int n_chk = 0;
    int n_err = 0;

    // Expected FIFO contents and sum, built from the values the responder hands out.
    int         exp_q[$];
    int         exp_sum  = 0;
    int         pop_cnt  = 0;
    int         req_idx  = 0;
    int         bad_at   = -1;
    logic [3:0] bad_val  = 4'd0;
    bit         stuck    = 1'b0;
    bit         spur     = 1'b0;

    int req_k[$];
    int done_k;
    int err_k;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Responder: returns ready plus a value one cycle after each request.
    initial begin : responder
        logic       rs;
        logic       pr;
        logic [3:0] v;
        ready = 1'b0;
        value = 4'd0;
        forever begin
            @(negedge clk);
            rs = req;
            pr = ready;
            @(posedge clk);
            #1;
            if (rs) begin
                if (stuck) begin
                    ready = 1'b0;
                end else begin
                    if (req_idx == bad_at) v = bad_val;
                    else                   v = 4'($urandom_range(1, 11));
                    req_idx++;
                    ready = 1'b1;
                    value = v;
                    if (v >= 4'd1 && v <= 4'd11) begin
                        exp_q.push_back(int'(v));
                        exp_sum += int'(v);
                    end
                end
            end else if (spur && pr) begin
                ready = 1'b1;
                value = 4'd15;
            end else begin
                ready = 1'b0;
            end
        end
    end

    // Consumer: every accepted head must match the oldest expected value.
    initial begin : consumer
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hFFFF_FFFF;
                chk("pop_data", 32'(out_data), e);
                pop_cnt++;
            end
        end
    end

    // Pulse start for one cycle; the next negedge is the first ISSUE cycle (k=0).
    task automatic kick();
        @(posedge clk);
        #1;
        exp_sum = 0;
        req_idx = 0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
    endtask

    // Observe up to max_k cycles, logging request cycles and stopping on done/error.
    task automatic run_seq(input int max_k, input int start_pulse_k);
        req_k.delete();
        done_k = -1;
        err_k  = -1;
        for (int k = 0; k < max_k; k++) begin
            @(negedge clk);
            start = (k == start_pulse_k);
            if (req) req_k.push_back(k);
            if (done)  begin done_k = k; break; end
            if (error) begin err_k  = k; break; end
        end
        start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin : stimulus
        int p0;
        int seen;
        rst       = 1'b1;
        start     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        idle_cycles(2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_done_err", 32'({done, error}), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        rst = 1'b0;
        idle_cycles(2);

        // 1: free-running draws, consumer always ready
        p0 = pop_cnt;
        kick();
        run_seq(40, -1);
        chk("s1_req_count", 32'(req_k.size()), 32'd8);
        chk("s1_first_req", 32'(req_k.size() > 0 ? req_k[0] : -1), 32'd0);
        chk("s1_last_req", 32'(req_k.size() == 8 ? req_k[7] : -1), 32'd14);
        chk("s1_done_k", 32'(done_k), 32'd16);
        chk("s1_sum", 32'(sum), 32'(exp_sum));
        idle_cycles(1);
        chk("s1_busy_after", 32'(busy), 32'd0);
        idle_cycles(3);
        chk("s1_sum_hold", 32'(sum), 32'(exp_sum));
        chk("s1_pops", 32'(pop_cnt - p0), 32'd8);

        // 2: consumer stalled, FIFO fills and requests stop
        @(posedge clk); #1 out_ready = 1'b0;
        p0 = pop_cnt;
        kick();
        run_seq(30, -1);
        chk("s2_req_stall", 32'(req_k.size()), 32'd4);
        chk("s2_no_done", 32'(done_k), 32'hFFFF_FFFF);
        chk("s2_busy", 32'(busy), 32'd1);
        chk("s2_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1 out_ready = 1'b1;
        run_seq(60, -1);
        chk("s2_req_resume", 32'(req_k.size()), 32'd4);
        chk("s2_done_seen", 32'(done_k >= 0), 32'd1);
        chk("s2_sum", 32'(sum), 32'(exp_sum));
        idle_cycles(4);
        chk("s2_pops", 32'(pop_cnt - p0), 32'd8);

        // 3: ready never returns
        stuck = 1'b1;
        kick();
        run_seq(40, -1);
        chk("s3_req_count", 32'(req_k.size()), 32'd1);
        chk("s3_err_k", 32'(err_k), 32'(TO + 1));
        chk("s3_busy_at_err", 32'(busy), 32'd1);
        idle_cycles(1);
        chk("s3_busy_after", 32'(busy), 32'd0);
        chk("s3_sum", 32'(sum), 32'd0);
        chk("s3_fifo", 32'(out_valid), 32'd0);
        stuck = 1'b0;

        // 4a: value 0 on the fourth draw
        p0      = pop_cnt;
        bad_val = 4'd0;
        bad_at  = 3;
        kick();
        run_seq(40, -1);
        chk("s4a_err_k", 32'(err_k), 32'd8);
        chk("s4a_no_done", 32'(done_k), 32'hFFFF_FFFF);
        chk("s4a_sum", 32'(sum), 32'(exp_sum));
        idle_cycles(3);
        chk("s4a_pops", 32'(pop_cnt - p0), 32'd3);

        // 4b: value 12 on the first draw
        p0      = pop_cnt;
        bad_val = 4'd12;
        bad_at  = 0;
        kick();
        run_seq(40, -1);
        chk("s4b_err_k", 32'(err_k), 32'd2);
        chk("s4b_sum", 32'(sum), 32'd0);
        idle_cycles(3);
        chk("s4b_pops", 32'(pop_cnt - p0), 32'd0);
        chk("s4b_fifo", 32'(out_valid), 32'd0);
        bad_at = -1;

        // 5: reset while waiting for ready
        @(posedge clk); #1 out_ready = 1'b0;
        kick();
        seen = 1;
        for (int i = 0; i < 20 && seen < 3; i++) begin
            @(negedge clk);
            if (req) seen++;
        end
        chk("s5_reach_third_req", 32'(seen), 32'd3);
        chk("s5_fifo_before", 32'(out_valid), 32'd1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("s5_rst_req", 32'(req), 32'd0);
        chk("s5_rst_busy", 32'(busy), 32'd0);
        chk("s5_rst_out_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        exp_sum = 0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1 out_ready = 1'b1;
        p0 = pop_cnt;
        kick();
        run_seq(40, -1);
        chk("s5_req_count", 32'(req_k.size()), 32'd8);
        chk("s5_done_k", 32'(done_k), 32'd16);
        chk("s5_sum", 32'(sum), 32'(exp_sum));
        idle_cycles(3);
        chk("s5_pops", 32'(pop_cnt - p0), 32'd8);

        // 6: extra start mid-sequence and spurious ready during ISSUE
        spur = 1'b1;
        p0   = pop_cnt;
        kick();
        run_seq(40, 5);
        chk("s6_req_count", 32'(req_k.size()), 32'd8);
        chk("s6_last_req", 32'(req_k.size() == 8 ? req_k[7] : -1), 32'd14);
        chk("s6_done_k", 32'(done_k), 32'd16);
        chk("s6_no_err", 32'(err_k), 32'hFFFF_FFFF);
        chk("s6_sum", 32'(sum), 32'(exp_sum));
        @(posedge clk); #1 spur = 1'b0;
        idle_cycles(4);
        chk("s6_pops", 32'(pop_cnt - p0), 32'd8);
        chk("s6_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
